// File: rtl/bp_me_wormhole_mem_resp_sched_if.sv
// Request/link bundle for the mem-resp wormhole scheduler.
// The slave side is the scheduler; the master side is the requesters plus the link sink.
interface bp_me_wormhole_mem_resp_sched_if #(
    parameter int num_src_p      = 2,
    parameter int flit_width_p   = 64,
    parameter int packet_width_p = 640,
    parameter int len_width_p    = 4
) ();
    localparam int ID_W = (num_src_p > 1) ? $clog2(num_src_p) : 1;

    logic [num_src_p*packet_width_p-1:0] packet_i;
    logic [num_src_p*len_width_p-1:0]    len_i;
    logic [num_src_p-1:0]                v_i;
    logic [num_src_p-1:0]                yumi_o;
    logic [flit_width_p-1:0]             link_data_o;
    logic                                link_v_o;
    logic                                link_ready_i;
    logic [ID_W-1:0]                     grant_id_o;

    modport slave (
        input  packet_i, len_i, v_i, link_ready_i,
        output yumi_o, link_data_o, link_v_o, grant_id_o
    );

    modport master (
        output packet_i, len_i, v_i, link_ready_i,
        input  yumi_o, link_data_o, link_v_o, grant_id_o
    );
endinterface

// File: rtl/bp_me_wormhole_mem_resp_sched.sv
// Round-robin scheduler serialising pre-encoded mem-resp packets from several
// requesters onto one wormhole link, one whole packet at a time.
module bp_me_wormhole_mem_resp_sched #(
    parameter int num_src_p      = 2,
    parameter int flit_width_p   = 64,
    parameter int packet_width_p = 640,
    parameter int len_width_p    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_me_wormhole_mem_resp_sched_if.slave io
);
    localparam int ID_W  = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam int FLITS = 2 ** len_width_p;
    localparam int PAD_W = FLITS * flit_width_p;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                r_state;
    logic [ID_W-1:0]           r_last_grant;
    logic [ID_W-1:0]           r_id;
    logic [packet_width_p-1:0] r_packet;
    logic [len_width_p-1:0]    r_len;
    logic [len_width_p-1:0]    r_cnt;
    logic                      r_ready;

    logic [packet_width_p-1:0] w_pkt_slot [num_src_p];
    logic [len_width_p-1:0]    w_len_slot [num_src_p];
    logic [flit_width_p-1:0]   w_flit     [FLITS];
    logic [PAD_W-1:0]          w_padded;
    logic [ID_W-1:0]           w_ptr;
    logic [ID_W-1:0]           w_win;
    logic                      w_any;
    logic                      w_accept;
    logic                      w_send;
    logic [num_src_p-1:0]      w_onehot;

    for (genvar g = 0; g < num_src_p; g++) begin : g_slot
        assign w_pkt_slot[g] = io.packet_i[g*packet_width_p +: packet_width_p];
        assign w_len_slot[g] = io.len_i[g*len_width_p +: len_width_p];
    end

    // Flit indices past the end of the packet read as zero padding.
    if (packet_width_p >= PAD_W) begin : g_trunc
        assign w_padded = r_packet[PAD_W-1:0];
    end else begin : g_pad
        assign w_padded = {{(PAD_W-packet_width_p){1'b0}}, r_packet};
    end

    for (genvar g = 0; g < FLITS; g++) begin : g_flit
        assign w_flit[g] = w_padded[g*flit_width_p +: flit_width_p];
    end

    // Round-robin search starting one past the last winner, wrapping at num_src_p.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_ptr = r_last_grant;
        for (int unsigned k = 0; k < num_src_p; k++) begin
            w_ptr = (w_ptr == ID_W'(num_src_p - 1)) ? '0 : w_ptr + 1'b1;
            if (!w_any && io.v_i[w_ptr]) begin
                w_any = 1'b1;
                w_win = w_ptr;
            end
        end
    end

    // r_ready keeps the scheduler quiet for the first cycle after reset release.
    assign w_accept = reset_n_i && r_ready && (r_state == IDLE) && w_any;
    assign w_send   = reset_n_i && (r_state == SEND);

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    assign io.yumi_o      = w_accept ? w_onehot : '0;
    assign io.link_v_o    = w_send;
    assign io.link_data_o = w_send ? w_flit[r_cnt] : '0;
    assign io.grant_id_o  = w_send ? r_id : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_packet     <= '0;
            r_id         <= '0;
            r_last_grant <= ID_W'(num_src_p - 1);
            r_ready      <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_packet     <= w_pkt_slot[w_win];
                        r_len        <= w_len_slot[w_win];
                        r_id         <= w_win;
                        r_last_grant <= w_win;
                        r_cnt        <= '0;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (io.link_ready_i) begin
                        if (r_cnt == r_len) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_me_wormhole_mem_resp_sched.sv
// Directed bench for the mem-resp wormhole scheduler (2 sources, 64-bit flits, 640-bit packets).
module tb_bp_me_wormhole_mem_resp_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bp_me_wormhole_mem_resp_sched_if io ();

    bp_me_wormhole_mem_resp_sched #(
        .num_src_p      (2),
        .flit_width_p   (64),
        .packet_width_p (640),
        .len_width_p    (4)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (io)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] flit_val(input int s, input int k);
        return {16'hBEEF, 8'(s), 8'(k), 32'h1234_5678 + 32'(k * 7)};
    endfunction

    function automatic logic [63:0] exp_flit(input int s, input int k);
        return (k < 10) ? flit_val(s, k) : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled on the falling edge while out of reset.
    logic       prev_v   = 1'b0;
    logic [0:0] prev_gid = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("yumi_onehot", 64'($onehot0(io.yumi_o)), 64'd1);
            chk("yumi_needs_v", 64'(io.yumi_o & ~io.v_i), 64'd0);
            if (prev_v && io.link_v_o) chk("grant_stable", 64'(io.grant_id_o), 64'(prev_gid));
        end
        prev_v   = io.link_v_o;
        prev_gid = io.grant_id_o;
    end

    // Called in the yumi cycle; follows the packet to its bubble cycle.
    task automatic recv(input int src, input int len, input logic [31:0] stall, input string tag);
        int idx  = 0;
        int cyc  = 0;
        bit done = 1'b0;
        while (!done) begin
            tick();
            io.v_i         = '0;
            io.link_ready_i = !stall[cyc];
            if (io.link_v_o !== 1'b1) begin
                chk({tag, "_lv"}, 64'(io.link_v_o), 64'd1);
                done = 1'b1;
            end else begin
                chk({tag, "_data"}, io.link_data_o, exp_flit(src, idx));
                chk({tag, "_gid"}, 64'(io.grant_id_o), 64'(src));
                chk({tag, "_noyumi"}, 64'(io.yumi_o), 64'd0);
                if (io.link_ready_i) idx++;
                cyc++;
                if (idx > len || cyc >= 32) done = 1'b1;
            end
        end
        chk({tag, "_count"}, 64'(idx), 64'(len + 1));
        tick();
        io.link_ready_i = 1'b1;
        chk({tag, "_bubble_v"}, 64'(io.link_v_o), 64'd0);
        chk({tag, "_bubble_d"}, io.link_data_o, 64'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        io.v_i          = 2'b11;
        io.link_ready_i = 1'b1;
        io.len_i        = '0;
        io.packet_i     = '0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 10; k++)
                io.packet_i[s*640 + k*64 +: 64] = flit_val(s, k);

        tick();
        tick();
        chk("rst_yumi", 64'(io.yumi_o), 64'd0);
        chk("rst_lv", 64'(io.link_v_o), 64'd0);
        chk("rst_data", io.link_data_o, 64'd0);
        chk("rst_gid", 64'(io.grant_id_o), 64'd0);

        rst_n = 1'b1;
        #1;
        chk("post_rst_yumi", 64'(io.yumi_o), 64'd0);
        chk("post_rst_lv", 64'(io.link_v_o), 64'd0);

        // Both requesting with single-flit packets: grants alternate 0,1,0,1.
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("alt_yumi", 64'(io.yumi_o), (r % 2 == 1) ? 64'd2 : 64'd1);
            tick();
            chk("alt_lv", 64'(io.link_v_o), 64'd1);
            chk("alt_gid", 64'(io.grant_id_o), 64'(r % 2));
            chk("alt_data", io.link_data_o, flit_val(r % 2, 0));
            chk("alt_noyumi", 64'(io.yumi_o), 64'd0);
            if (r == 3) io.v_i = '0;
        end
        tick();
        chk("alt_end_lv", 64'(io.link_v_o), 64'd0);
        chk("alt_end_yumi", 64'(io.yumi_o), 64'd0);

        io.len_i = {4'd0, 4'd9};
        io.v_i   = 2'b01;
        #1;
        chk("burst_yumi", 64'(io.yumi_o), 64'd1);
        recv(0, 9, 32'h0, "burst10");

        io.len_i = {4'd5, 4'd0};
        io.v_i   = 2'b10;
        #1;
        chk("stall_yumi", 64'(io.yumi_o), 64'd2);
        recv(1, 5, 32'h6, "stall");

        io.len_i = {4'd0, 4'd0};
        io.v_i   = 2'b01;
        #1;
        chk("len0_yumi", 64'(io.yumi_o), 64'd1);
        recv(0, 0, 32'h0, "len0");

        io.len_i = {4'd15, 4'd0};
        io.v_i   = 2'b10;
        #1;
        chk("len15_yumi", 64'(io.yumi_o), 64'd2);
        recv(1, 15, 32'h0, "len15");

        // Reset during flit 3 of a 10-flit packet from src0.
        io.len_i = {4'd0, 4'd9};
        io.v_i   = 2'b01;
        #1;
        chk("mid_yumi", 64'(io.yumi_o), 64'd1);
        for (int f = 0; f < 4; f++) begin
            tick();
            io.v_i = '0;
            chk("mid_data", io.link_data_o, flit_val(0, f));
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_lv", 64'(io.link_v_o), 64'd0);
        chk("mid_rst_data", io.link_data_o, 64'd0);
        rst_n  = 1'b1;
        io.v_i = 2'b11;
        #1;
        chk("mid_hold_yumi", 64'(io.yumi_o), 64'd0);
        chk("mid_hold_lv", 64'(io.link_v_o), 64'd0);
        tick();
        chk("mid_regrant", 64'(io.yumi_o), 64'd1);
        recv(0, 9, 32'h0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bp_me_wormhole_mem_resp_sched.md
BP_ME_WORMHOLE_MEM_RESP_SCHED -- requirements
Module: bp_me_wormhole_mem_resp_sched

Interface
REQ-001 SHALL have parameter num_src_p, default 2, number of requesters sharing one mem-resp wormhole link (2..8).
REQ-002 SHALL have parameter flit_width_p, default 64, link flit width in bits.
REQ-003 SHALL have parameter packet_width_p, default 640, width of one pre-encoded mem-resp wormhole packet.
REQ-004 SHALL have parameter len_width_p, default 4, width of the packet len field (flits minus one).
REQ-005 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n_i, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port packet_i, input, num_src_p*packet_width_p, per-requester packet; slot i at [i*packet_width_p +: packet_width_p].
REQ-008 SHALL have port len_i, input, num_src_p*len_width_p, per-requester flit count minus one, same slot packing.
REQ-009 SHALL have port v_i, input, num_src_p, per-requester valid.
REQ-010 SHALL have port yumi_o, output, num_src_p, one-hot accept; packet of slot i consumed when yumi_o[i]=1.
REQ-011 SHALL have port link_data_o, output, flit_width_p, current flit.
REQ-012 SHALL have port link_v_o, output, 1, flit valid.
REQ-013 SHALL have port link_ready_i, input, 1, link accepts flit when link_v_o&link_ready_i.
REQ-014 SHALL have port grant_id_o, output, max(1,clog2(num_src_p)), id of requester owning the link; valid while link_v_o=1.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, SEND.
REQ-016 SHALL, in IDLE with any v_i set, select one winner by round-robin, searching from (last_grant+1) mod num_src_p upward with wrap.
REQ-017 SHALL assert yumi_o[winner] combinationally in that IDLE cycle only; yumi_o SHALL be zero in SEND and in IDLE with v_i=0.
REQ-018 SHALL, on the yumi cycle, register the winner's packet, len and id, set flit counter to 0, update last_grant to winner, and enter SEND next cycle.
REQ-019 SHALL, in SEND, drive link_v_o=1 and link_data_o = packet bits [cnt*flit_width_p +: flit_width_p], bits beyond packet_width_p zero.
REQ-020 SHALL hold link_data_o, grant_id_o stable while link_v_o=1 and link_ready_i=0 (no flit drop, no advance).
REQ-021 SHALL, on handshake with cnt<len, increment cnt by 1; with cnt==len, return to IDLE next cycle.
REQ-022 SHALL emit exactly len+1 flits per packet, lowest flit first; len=0 yields one flit.
REQ-023 SHALL emit all-zero flits for indices beyond ceil(packet_width_p/flit_width_p)-1 when len exceeds packet size (no error).
REQ-024 SHALL keep a one-cycle IDLE bubble between packets; no back-to-back accept in the final SEND cycle.
REQ-025 SHALL never interleave flits of two packets; a granted packet owns the link until its last flit handshakes.
REQ-026 SHALL ignore v_i changes while in SEND; v_i deassertion by a non-granted requester has no effect.
REQ-027 SHALL drive link_v_o=0 and link_data_o=0 in IDLE.
REQ-028 SHALL keep cnt width clog2 of 2^len_width_p; no wrap occurs since cnt<=len.

Reset
REQ-029 SHALL, when reset_n_i=0 at a clock edge, enter IDLE, clear cnt, packet and len registers, and set last_grant=num_src_p-1 (requester 0 first priority).
REQ-030 SHALL hold yumi_o=0, link_v_o=0, link_data_o=0, grant_id_o=0 during and the cycle after reset.
REQ-031 SHALL, on reset mid-SEND, abandon the packet; link_v_o=0 from the next cycle, no remaining flits sent after reset release.

Verification
REQ-032 SHALL cover: reset, v_i=2'b11 -> yumi_o=2'b01, then after 1 bubble src1 granted; alternation 0,1,0,1 under sustained requests.
REQ-033 SHALL cover: src0 len=9, flit 64, link_ready_i=1 -> 10 flits on consecutive cycles, flit k = packet[64k+:64], then link_v_o=0 one cycle.
REQ-034 SHALL cover: link_ready_i toggling 1,0,0,1 mid-packet -> link_data_o held during stalls, flit count still len+1, no duplicates.
REQ-035 SHALL cover: len=0 -> single flit, FSM back to IDLE; len=15 with 640-bit packet -> flits 10..15 all zero.
REQ-036 SHALL cover: reset_n_i=0 during flit 3 of 10 -> link_v_o=0 next cycle, last_grant reset, next grant goes to src0.
REQ-037 SHALL check: yumi_o one-hot or zero always, yumi_o[i] only with v_i[i]=1, grant_id_o constant within a packet.
